sys_array_stream_fetcher: RTL

- Second-generation fetcher/sequencer around sys_array_basic. Computes C = W × B, with W being M×K weights and B being K×N activations.
- Generalised in width, signedness and tile dims. Adds a start/busy handshake and output valid/ready backpressure.
- Adds accumulation across K-tiles into ACC_WIDTH-bit saturating accumulators, and a synchronous abort.
- Sits between the tile loader and the result writer.

---
 rtl/sys_array_pkg.sv | 40 ++++
 rtl/sys_array_acc_bank.sv | 47 ++++
 rtl/sys_array_stream_fetcher.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// Shared types, shift-register control codes and the saturation helper for the
// stream fetcher and its accumulator bank.
package sys_array_pkg;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LOAD  = 2'b01;
  localparam logic [1:0] SR_WRITE = 2'b10;
  localparam logic [1:0] SR_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_HOLD
  } fsm_state_t;

  // Internal datapath width: wide enough that sums and accumulate-adds never wrap
  // before saturation, for ACC_WIDTH up to 64 and modest K.
  localparam int SAT_W = 80;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t sat_acc(input wide_t value, input logic signed_mode,
                                    input int acc_width);
    wide_t one;
    wide_t hi;
    wide_t lo;
    one = wide_t'(1);
    if (signed_mode) begin
      hi = (one <<< (acc_width - 1)) - one;
      lo = -(one <<< (acc_width - 1));
    end else begin
      hi = (one <<< acc_width) - one;
      lo = '0;
    end
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/sys_array_acc_bank.sv
// M*N saturating accumulators: load either overwrites with the tile result or
// adds it to the held value; reset clears the whole bank.
module sys_array_acc_bank
  import sys_array_pkg::*;
#(
  parameter int ARRAY_M   = 2,
  parameter int ARRAY_N   = 2,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic                                 accumulate,
  input  wide_t                                tile [ARRAY_M*ARRAY_N],
  output logic [ARRAY_M*ARRAY_N*ACC_WIDTH-1:0] acc
);

  localparam int CELLS = ARRAY_M * ARRAY_N;

  logic [ACC_WIDTH-1:0] acc_q   [CELLS];
  wide_t                acc_ext [CELLS];

  always_comb begin
    for (int i = 0; i < CELLS; i++) begin
      if (SIGNED != 0) acc_ext[i] = wide_t'(signed'(acc_q[i]));
      else             acc_ext[i] = wide_t'(acc_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) acc_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < CELLS; i++)
        acc_q[i] <= ACC_WIDTH'(sat_acc(accumulate ? acc_ext[i] + tile[i] : tile[i],
                                       SIGNED != 0, ACC_WIDTH));
    end
  end

  // Cell 0 (row 0, column 0) sits in the most significant slot.
  always_comb begin
    acc = '0;
    for (int i = 0; i < CELLS; i++) acc[(CELLS-1-i)*ACC_WIDTH +: ACC_WIDTH] = acc_q[i];
  end

endmodule

// File: rtl/sys_array_stream_fetcher.sv
// Tile sequencer computing C = W x B: weight-stationary, B rows streamed with a
// k-cycle skew, results drained through per-row write registers into the accumulators.
module sys_array_stream_fetcher
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_M    = 2,
  parameter int ARRAY_K    = 2,
  parameter int ARRAY_N    = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    reload_w,
  input  logic                                    accumulate,
  input  logic                                    abort,
  input  logic [ARRAY_M*ARRAY_K*DATA_WIDTH-1:0]   weight_data,
  input  logic [ARRAY_K*ARRAY_N*DATA_WIDTH-1:0]   input_data_b,
  output logic                                    busy,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ARRAY_M*ARRAY_N*ACC_WIDTH-1:0]    out_data
);

  localparam int LATENCY = ARRAY_K + ARRAY_N + ARRAY_M + 2;
  localparam int CNT_W   = $clog2(LATENCY + 1);

  typedef logic [DATA_WIDTH-1:0] elem_t;

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int               cnt_i;
  logic             busy_d, valid_d, acc_mode_q;
  logic             accept, weights_load, acc_load;

  elem_t      w_q    [ARRAY_M][ARRAY_K];
  elem_t      rd_q   [ARRAY_K][ARRAY_N];
  wide_t      psum_q [ARRAY_M][ARRAY_N];
  wide_t      psum_d [ARRAY_M][ARRAY_N];
  wide_t      wr_q   [ARRAY_M][ARRAY_N];
  wide_t      wr_in  [ARRAY_M];
  wide_t      tile   [ARRAY_M*ARRAY_N];
  logic [1:0] rd_ctrl [ARRAY_K];
  logic [1:0] wr_ctrl [ARRAY_M];

  function automatic wide_t ext(input elem_t x);
    if (SIGNED != 0) return wide_t'(signed'(x));
    return wide_t'(x);
  endfunction

  assign cnt_i = 32'(cnt_q);

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy;
    valid_d      = out_valid;
    accept       = 1'b0;
    weights_load = 1'b0;
    acc_load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          weights_load = reload_w;
          cnt_d        = CNT_W'(1);
          busy_d       = 1'b1;
          state_d      = ST_FEED;
        end
      end
      ST_FEED, ST_DRAIN: begin
        if (abort) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_FEED && cnt_i == ARRAY_K + ARRAY_N) state_d = ST_DRAIN;
          if (state_q == ST_DRAIN && cnt_i == LATENCY - 1) begin
            acc_load = 1'b1;
            cnt_d    = '0;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        valid_d = 1'b1;
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      acc_mode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      if (accept) acc_mode_q <= accumulate;
    end
  end

  // Read register k streams row k of B during cnt = k+1 .. k+N; write register m
  // captures row m of C during cnt = K+m+2 .. K+m+1+N.
  always_comb begin
    for (int k = 0; k < ARRAY_K; k++) begin
      rd_ctrl[k] = SR_HOLD;
      if (accept) rd_ctrl[k] = SR_LOAD;
      else if (state_q == ST_FEED && cnt_i >= k + 1 && cnt_i <= k + ARRAY_N)
        rd_ctrl[k] = SR_SHIFT;
    end
    for (int m = 0; m < ARRAY_M; m++) begin
      wr_ctrl[m] = SR_HOLD;
      if ((state_q == ST_FEED || state_q == ST_DRAIN) &&
          cnt_i >= ARRAY_K + m + 2 && cnt_i <= ARRAY_K + m + 1 + ARRAY_N)
        wr_ctrl[m] = SR_WRITE;
    end
  end

  // The element leaving read register k is B[k][n] with n = cnt-k-1, so each
  // partial sum receives at most one product per cycle.
  always_comb begin
    psum_d = psum_q;
    for (int k = 0; k < ARRAY_K; k++)
      for (int n = 0; n < ARRAY_N; n++)
        if (rd_ctrl[k] == SR_SHIFT && cnt_i == k + n + 1)
          for (int m = 0; m < ARRAY_M; m++)
            psum_d[m][n] = psum_d[m][n] + ext(w_q[m][k]) * ext(rd_q[k][0]);
  end

  always_comb begin
    for (int m = 0; m < ARRAY_M; m++) begin
      wr_in[m] = '0;
      for (int n = 0; n < ARRAY_N; n++)
        if (cnt_i == ARRAY_K + m + 2 + n) wr_in[m] = psum_q[m][n];
    end
  end

  // NOTE: datapath registers carry no reset; each accepted tile reloads or clears
  // them before any value is consumed.
  always_ff @(posedge clk) begin
    if (weights_load)
      for (int m = 0; m < ARRAY_M; m++)
        for (int k = 0; k < ARRAY_K; k++)
          w_q[m][k] <= weight_data[(ARRAY_M*ARRAY_K-1-(m*ARRAY_K+k))*DATA_WIDTH +: DATA_WIDTH];
    for (int k = 0; k < ARRAY_K; k++) begin
      case (rd_ctrl[k])
        SR_LOAD:
          for (int n = 0; n < ARRAY_N; n++)
            rd_q[k][n] <= input_data_b[(ARRAY_K*ARRAY_N-1-(k*ARRAY_N+n))*DATA_WIDTH +: DATA_WIDTH];
        SR_SHIFT: begin
          for (int n = 0; n < ARRAY_N - 1; n++) rd_q[k][n] <= rd_q[k][n+1];
          rd_q[k][ARRAY_N-1] <= '0;
        end
        default: ;
      endcase
    end
    for (int m = 0; m < ARRAY_M; m++)
      for (int n = 0; n < ARRAY_N; n++)
        psum_q[m][n] <= accept ? '0 : psum_d[m][n];
    for (int m = 0; m < ARRAY_M; m++) begin
      if (wr_ctrl[m] == SR_WRITE) begin
        for (int n = 0; n < ARRAY_N - 1; n++) wr_q[m][n] <= wr_q[m][n+1];
        wr_q[m][ARRAY_N-1] <= wr_in[m];
      end
    end
  end

  always_comb begin
    for (int m = 0; m < ARRAY_M; m++)
      for (int n = 0; n < ARRAY_N; n++)
        tile[m*ARRAY_N+n] = wr_q[m][n];
  end

  sys_array_acc_bank #(
    .ARRAY_M   (ARRAY_M),
    .ARRAY_N   (ARRAY_N),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_acc_bank (
    .clk        (clk),
    .reset      (reset),
    .load       (acc_load),
    .accumulate (acc_mode_q),
    .tile       (tile),
    .acc        (out_data)
  );

endmodule
